// File: rtl/writeback_stage.sv
// Final pipeline stage: selects the retiring result, waits for load data with a
// bounded timeout, and drives the single register-file write port.
module writeback_stage #(
    parameter int LOAD_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_reg_write,
    input  logic [4:0]  in_dest,
    input  logic [1:0]  in_sel,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_pc_plus8,
    input  logic [1:0]  in_load_size,
    input  logic        in_load_signed,
    input  logic [1:0]  in_byte_off,
    input  logic        flush,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        reg_write_en,
    output logic [4:0]  write_addr,
    output logic [31:0] write_data,
    output logic        load_timeout
);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(LOAD_TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        pend_we_q;
    logic [4:0]  pend_dest_q;
    logic [1:0]  pend_size_q;
    logic        pend_signed_q;
    logic [1:0]  pend_off_q;
    logic        reg_write_en_q;
    logic [4:0]  write_addr_q;
    logic [31:0] write_data_q;
    logic        load_timeout_q;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data_d;
    logic [31:0] imm_data_d;

    assign in_ready = (state_q == IDLE);

    // Little-endian lane pick from the latched offset, then sign/zero extend.
    always_comb begin
        byte_sel = mem_rsp_data[8*pend_off_q +: 8];
        half_sel = pend_off_q[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
        case (pend_size_q)
            2'd0:    load_data_d = {{24{pend_signed_q & byte_sel[7]}}, byte_sel};
            2'd1:    load_data_d = {{16{pend_signed_q & half_sel[15]}}, half_sel};
            default: load_data_d = mem_rsp_data;
        endcase
        imm_data_d = (in_sel == 2'd2) ? in_pc_plus8 : in_alu_result;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= 8'd0;
            pend_we_q      <= 1'b0;
            pend_dest_q    <= 5'd0;
            pend_size_q    <= 2'd0;
            pend_signed_q  <= 1'b0;
            pend_off_q     <= 2'd0;
            reg_write_en_q <= 1'b0;
            write_addr_q   <= 5'd0;
            write_data_q   <= 32'd0;
            load_timeout_q <= 1'b0;
        end else begin
            reg_write_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (in_sel == 2'd1) begin
                            pend_we_q     <= in_reg_write;
                            pend_dest_q   <= in_dest;
                            pend_size_q   <= in_load_size;
                            pend_signed_q <= in_load_signed;
                            pend_off_q    <= in_byte_off;
                            cnt_q         <= 8'd0;
                            state_q       <= WAIT_LOAD;
                        end else begin
                            reg_write_en_q <= in_reg_write && (in_dest != 5'd0) && (in_sel != 2'd3);
                            write_addr_q   <= in_dest;
                            write_data_q   <= imm_data_d;
                        end
                    end
                end
                WAIT_LOAD: begin
                    // A flush beats a response arriving in the same cycle.
                    if (flush) begin
                        state_q <= IDLE;
                    end else if (mem_rsp_valid) begin
                        reg_write_en_q <= pend_we_q && (pend_dest_q != 5'd0);
                        write_addr_q   <= pend_dest_q;
                        write_data_q   <= load_data_d;
                        state_q        <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        load_timeout_q <= 1'b1;
                        state_q        <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign reg_write_en = reg_write_en_q;
    assign write_addr   = write_addr_q;
    assign write_data   = write_data_q;
    assign load_timeout = load_timeout_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed plus randomized bench for writeback_stage, checked against a
// transaction-level model of the stage's retire rules.
module tb_writeback_stage;

    localparam int LT = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_reg_write;
    logic [4:0]  in_dest;
    logic [1:0]  in_sel;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc_plus8;
    logic [1:0]  in_load_size;
    logic        in_load_signed;
    logic [1:0]  in_byte_off;
    logic        flush;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        reg_write_en;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        load_timeout;

    int vectors = 0;
    int miscompares = 0;
    logic exp_to = 1'b0;

    writeback_stage #(.LOAD_TIMEOUT(LT)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_write(in_reg_write), .in_dest(in_dest), .in_sel(in_sel),
        .in_alu_result(in_alu_result), .in_pc_plus8(in_pc_plus8),
        .in_load_size(in_load_size), .in_load_signed(in_load_signed),
        .in_byte_off(in_byte_off), .flush(flush),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .reg_write_en(reg_write_en), .write_addr(write_addr),
        .write_data(write_data), .load_timeout(load_timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference load extraction: shift, mask, and wrap negative values.
    function automatic logic [31:0] ext_model(input int size, input bit sgn, input int off,
                                              input logic [31:0] data);
        logic [31:0] v;
        if (size == 0) begin
            v = (data >> (8 * off)) & 32'hFF;
            if (sgn && v >= 32'd128) v = v - 32'd256;
        end else if (size == 1) begin
            v = (data >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
            if (sgn && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = data;
        end
        return v;
    endfunction

    task automatic idle_cycle();
        in_valid      = 1'b0;
        flush         = 1'($urandom % 2);
        mem_rsp_valid = 1'($urandom % 2);
        mem_rsp_data  = $urandom;
        step();
        chk("idle_we", 32'(reg_write_en), 32'(1'b0));
        chk("idle_ready", 32'(in_ready), 32'(1'b1));
        chk("idle_timeout_flag", 32'(load_timeout), 32'(exp_to));
    endtask

    task automatic alu_op(input logic [1:0] sel, input logic [4:0] dest, input logic we,
                          input logic [31:0] alu, input logic [31:0] pc);
        logic exp_we;
        in_valid       = 1'b1;
        in_sel         = sel;
        in_dest        = dest;
        in_reg_write   = we;
        in_alu_result  = alu;
        in_pc_plus8    = pc;
        in_load_size   = 2'($urandom);
        in_load_signed = 1'($urandom);
        in_byte_off    = 2'($urandom);
        flush          = 1'($urandom % 2);
        mem_rsp_valid  = 1'($urandom % 2);
        mem_rsp_data   = $urandom;
        chk("alu_ready", 32'(in_ready), 32'(1'b1));
        step();
        exp_we = we && (dest != 0) && (sel != 2'd3);
        chk("alu_we", 32'(reg_write_en), 32'(exp_we));
        if (exp_we) begin
            chk("alu_addr", 32'(write_addr), 32'(dest));
            chk("alu_data", write_data, (sel == 2'd2) ? pc : alu);
        end
        chk("alu_timeout_flag", 32'(load_timeout), 32'(exp_to));
    endtask

    // rsp_k / flush_k: cycle after the transfer in which the response / flush
    // is presented (0 = never).
    task automatic load_op(input int size, input bit sgn, input int off, input logic [4:0] dest,
                           input logic we, input logic [31:0] data, input int rsp_k,
                           input int flush_k);
        logic exp_we;
        in_valid       = 1'b1;
        in_sel         = 2'd1;
        in_dest        = dest;
        in_reg_write   = we;
        in_load_size   = 2'(size);
        in_load_signed = sgn;
        in_byte_off    = 2'(off);
        in_alu_result  = $urandom;
        in_pc_plus8    = $urandom;
        flush          = 1'b0;
        mem_rsp_valid  = 1'($urandom % 2);
        mem_rsp_data   = $urandom;
        chk("load_xfer_ready", 32'(in_ready), 32'(1'b1));
        step();
        in_valid = 1'($urandom % 2);
        in_sel   = 2'($urandom);
        chk("load_xfer_we", 32'(reg_write_en), 32'(1'b0));
        for (int k = 1; k <= LT + 2; k++) begin
            mem_rsp_valid = (k == rsp_k);
            mem_rsp_data  = (k == rsp_k) ? data : $urandom;
            flush         = (k == flush_k);
            chk("load_wait_ready", 32'(in_ready), 32'(1'b0));
            step();
            if (k == flush_k) begin
                chk("flush_we", 32'(reg_write_en), 32'(1'b0));
                chk("flush_ready", 32'(in_ready), 32'(1'b1));
                break;
            end else if (k == rsp_k) begin
                exp_we = we && (dest != 0);
                chk("load_we", 32'(reg_write_en), 32'(exp_we));
                if (exp_we) begin
                    chk("load_addr", 32'(write_addr), 32'(dest));
                    chk("load_data", write_data, ext_model(size, sgn, off, data));
                end
                chk("load_ready_after", 32'(in_ready), 32'(1'b1));
                break;
            end else if (k == LT) begin
                exp_to = 1'b1;
                chk("timeout_we", 32'(reg_write_en), 32'(1'b0));
                chk("timeout_ready", 32'(in_ready), 32'(1'b1));
                chk("timeout_flag_set", 32'(load_timeout), 32'(1'b1));
                break;
            end else begin
                chk("load_wait_we", 32'(reg_write_en), 32'(1'b0));
                chk("load_wait_flag", 32'(load_timeout), 32'(exp_to));
            end
        end
        in_valid      = 1'b0;
        mem_rsp_valid = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_we"}, 32'(reg_write_en), 32'(1'b0));
        chk({tag, "_addr"}, 32'(write_addr), 32'd0);
        chk({tag, "_data"}, write_data, 32'd0);
        chk({tag, "_flag"}, 32'(load_timeout), 32'(1'b0));
        chk({tag, "_ready"}, 32'(in_ready), 32'(1'b1));
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        in_valid = 1'b0; in_reg_write = 1'b0; in_dest = 5'd0; in_sel = 2'd0;
        in_alu_result = 32'd0; in_pc_plus8 = 32'd0; in_load_size = 2'd0;
        in_load_signed = 1'b0; in_byte_off = 2'd0; flush = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0;
        step();
        step();
        check_reset_state("reset");
        reset_n = 1'b1;
        step();

        // Directed sequence
        alu_op(2'd0, 5'd5, 1'b1, 32'hDEADBEEF, 32'h0);
        alu_op(2'd0, 5'd1, 1'b1, 32'h11111111, 32'h0);
        alu_op(2'd0, 5'd2, 1'b1, 32'h22222222, 32'h0);
        alu_op(2'd0, 5'd3, 1'b1, 32'h33333333, 32'h0);
        alu_op(2'd2, 5'd31, 1'b1, 32'h12345678, 32'h00400010);
        alu_op(2'd0, 5'd0, 1'b1, 32'hCAFEF00D, 32'h0);
        alu_op(2'd3, 5'd7, 1'b1, 32'hCAFEF00D, 32'h0);
        idle_cycle();
        load_op(0, 1'b1, 3, 5'd9, 1'b1, 32'h80123456, 4, 0);
        load_op(1, 1'b0, 2, 5'd10, 1'b1, 32'h80123456, 4, 0);
        load_op(1, 1'b1, 3, 5'd11, 1'b1, 32'h80123456, 1, 0);
        load_op(2, 1'b1, 1, 5'd12, 1'b1, 32'h80123456, 2, 0);
        load_op(3, 1'b0, 2, 5'd13, 1'b1, 32'hF00DCAFE, 1, 0);
        load_op(0, 1'b0, 1, 5'd0, 1'b1, 32'h80123456, 1, 0);
        load_op(0, 1'b0, 1, 5'd14, 1'b0, 32'h80123456, 2, 0);
        load_op(0, 1'b1, 0, 5'd15, 1'b1, 32'hAABBCCDD, 3, 3);
        alu_op(2'd0, 5'd6, 1'b1, 32'h0BADF00D, 32'h0);
        load_op(2, 1'b0, 0, 5'd16, 1'b1, 32'h01020304, 0, 0);
        idle_cycle();
        alu_op(2'd0, 5'd17, 1'b1, 32'h55AA55AA, 32'h0);
        load_op(2, 1'b0, 0, 5'd18, 1'b1, 32'h01020304, LT, 0);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            n = $urandom_range(0, 3);
            if (n == 0) begin
                idle_cycle();
            end else if (n == 1) begin
                alu_op(($urandom % 3 == 0) ? 2'd3 : (($urandom % 2) ? 2'd2 : 2'd0),
                       ($urandom % 6 == 0) ? 5'd0 : 5'($urandom),
                       1'($urandom % 4 != 0), $urandom, $urandom);
            end else begin
                int rk;
                rk = $urandom_range(1, LT + 2);
                load_op($urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3),
                        ($urandom % 6 == 0) ? 5'd0 : 5'($urandom),
                        1'($urandom % 4 != 0), $urandom, rk,
                        ($urandom % 6 == 0) ? $urandom_range(1, rk) : 0);
            end
        end

        // Reset mid-load, then a stray response must not write.
        load_op(0, 1'b1, 0, 5'd20, 1'b1, 32'h0, 0, 0);
        in_valid = 1'b1; in_sel = 2'd1; in_dest = 5'd21; in_reg_write = 1'b1;
        in_load_size = 2'd2; mem_rsp_valid = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        #2;
        reset_n = 1'b0;
        #1;
        exp_to = 1'b0;
        check_reset_state("async_reset");
        step();
        #2;
        reset_n = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hFFFFFFFF;
        step();
        mem_rsp_valid = 1'b0;
        check_reset_state("post_reset_rsp");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage of the CPU datapath and the sole driver of the register file write port. It accepts retiring instructions from the memory stage, selects the result (ALU, load data, or link address), sign/zero-extends sub-word loads, and waits for variable-latency data-memory responses. Writes to register 0 are suppressed here, a rule the register file also enforces.

## Interface
- LOAD_TIMEOUT, 255: max cycles spent in WAIT_LOAD before the load is abandoned (1..255).

- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  memory stage presents an instruction.
- in_ready  out  1  stage accepts; transfer when in_valid && in_ready.
- in_reg_write  in  1  instruction writes a register.
- in_dest  in  5  destination register.
- in_sel  in  2  result select: 0 ALU, 1 load, 2 link, 3 reserved (no write).
- in_alu_result  in  32  ALU result.
- in_pc_plus8  in  32  link address.
- in_load_size  in  2  0 byte, 1 half, 2 word, 3 treated as word.
- in_load_signed  in  1  sign-extend sub-word load.
- in_byte_off  in  2  address[1:0] of the load.
- flush  in  1  abort a pending load; no write.
- mem_rsp_valid  in  1  load data valid this cycle.
- mem_rsp_data  in  32  load word, little-endian.
- reg_write_en  out  1  one-cycle write strobe to the register file.
- write_addr  out  5  write address.
- write_data  out  32  write data.
- load_timeout  out  1  sticky error flag, cleared only by reset.

## Operation
- States: IDLE, WAIT_LOAD. in_ready = (state == IDLE), combinational.
- IDLE, transfer with in_sel != 1: next edge registers reg_write_en = in_reg_write && in_dest != 0 && in_sel != 3, write_addr = in_dest, write_data = ALU result or in_pc_plus8. State stays IDLE.
- IDLE, transfer with in_sel == 1: latch dest, reg_write, size, signed, offset; counter cleared; go to WAIT_LOAD. reg_write_en = 0 next cycle.
- WAIT_LOAD, mem_rsp_valid && !flush: extract the result and register a write as above (suppressed if reg_write is 0 or dest is 0). Return to IDLE.
- Extraction:
  - byte = data[8*off +: 8].
  - half = off[1] ? data[31:16] : data[15:0], with off[0] ignored.
  - word = data, with offset ignored.
  - Extension is sign or zero per in_load_signed.
- WAIT_LOAD, flush (any mem_rsp_valid): no write, return to IDLE. Flush wins over a simultaneous response. flush in IDLE has no effect.
- WAIT_LOAD, neither: counter increments. When the counter equals LOAD_TIMEOUT-1 with no response, set load_timeout, drop the write, and return to IDLE.
- mem_rsp_valid in IDLE is ignored.
- Reset (any time, including mid-load): state IDLE, counter 0, reg_write_en 0, write_addr 0, write_data 0, load_timeout 0. The pending load is discarded.

## Timing
- All outputs except in_ready are registered.
- Non-load: write strobe 1 cycle after transfer. Throughput is 1 per cycle with in_ready held at 1.
- Load: response can arrive at the earliest 1 cycle after transfer. The write strobe comes 1 cycle after the response cycle.
- in_ready is 0 from the cycle after the load transfer through the response cycle, and 1 again the following cycle.
- Minimum load occupancy: 2 cycles (transfer, response).
- Timeout: with no response, the flag rises LOAD_TIMEOUT cycles after the transfer edge. in_ready returns 1 on the same edge.
- reg_write_en is never high for two cycles from the same instruction.

## Test plan
- Reset, then ALU op dest=5, result 0xDEADBEEF, reg_write=1 -> next cycle reg_write_en=1, write_addr=5, write_data=0xDEADBEEF. Three back-to-back ALU ops -> three consecutive strobes, in_ready held at 1.
- Link op dest=31, pc_plus8=0x00400010 -> write_data=0x00400010. ALU op with dest=0 -> reg_write_en stays 0.
- Signed byte load, off=3, response 0x80123456 after 4 cycles -> write_data=0xFFFFFF80. Unsigned half load, off=2, same data -> 0x00008012. in_ready=0 during the wait.
- Flush asserted together with mem_rsp_valid in WAIT_LOAD -> no write. in_ready=1 next cycle. Following ALU op writes normally.
- LOAD_TIMEOUT=8, load with no response -> load_timeout=1 after 8 cycles, no write, state IDLE. The flag persists until reset_n is asserted.
- reset_n asserted low mid-WAIT_LOAD, then the response arrives after release -> no write, all outputs 0, in_ready=1.
